// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - iterative SLL/SRL/SRA shift unit, STEP bits per cycle; optional rotate-left via ITER_SHIFTER_ROTATE_EN
module iter_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dout,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [1:0]         MODE_SRL = 2'b01;
   localparam logic [1:0]         MODE_SRA = 2'b10;
   localparam logic [1:0]         MODE_ROT = 2'b11;
   localparam logic [SHAMT_W-1:0] STEP_C   = SHAMT_W'(STEP);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic [1:0]         mode_q, mode_d;
   logic [WIDTH-1:0]   dout_q, dout_d;

   logic [SHAMT_W-1:0] step_amt;
   logic [SHAMT_W-1:0] rem_next;
   logic [WIDTH-1:0]   shifted;

`ifdef ITER_SHIFTER_ROTATE_EN
   logic [SHAMT_W:0]   rot_back;
`endif

   // One step of the working register: shift by min(STEP, remaining) in the captured mode
   always_comb begin
      step_amt = (rem_q < STEP_C) ? rem_q : STEP_C;
      rem_next = rem_q - step_amt;
`ifdef ITER_SHIFTER_ROTATE_EN
      rot_back = (SHAMT_W+1)'(WIDTH) - {1'b0, step_amt};
`endif
      case (mode_q)
         MODE_SRL: shifted = work_q >> step_amt;
         // Working MSB still holds the captured sign, so an arithmetic shift keeps replicating it
         MODE_SRA: shifted = $unsigned($signed(work_q) >>> step_amt);
`ifdef ITER_SHIFTER_ROTATE_EN
         MODE_ROT: shifted = (work_q << step_amt) | (work_q >> rot_back);
`else
         MODE_ROT: shifted = work_q << step_amt;
`endif
         default:  shifted = work_q << step_amt;
      endcase
   end

   // Next-state logic: accept start in IDLE/DONE, iterate in SHIFT, DONE is a single cycle
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      dout_d  = dout_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               mode_d = mode;
               work_d = din;
               rem_d  = shamt;
               if (shamt == '0) begin
                  state_d = ST_DONE;
                  dout_d  = din;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            work_d = shifted;
            rem_d  = rem_next;
            if (rem_next == '0) begin
               state_d = ST_DONE;
               dout_d  = shifted;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         work_q  <= '0;
         rem_q   <= '0;
         mode_q  <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         dout_q  <= dout_d;
      end
   end

   // Status outputs are decoded straight from the state register so reset clears them at once
   always_comb begin
      busy = (state_q == ST_SHIFT);
      done = (state_q == ST_DONE);
      dout = dout_q;
   end

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - scoreboard bench for iter_shifter at STEP=1 and STEP=4
module tb_iter_shifter;

   localparam int W  = 32;
   localparam int SW = 5;

   typedef struct {
      logic [W-1:0] val;
      int           cyc;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic [1:0]         start_v;
   logic [1:0][1:0]    mode_v;
   logic [1:0][SW-1:0] shamt_v;
   logic [1:0][W-1:0]  din_v;
   logic [W-1:0]       dout0, dout1;
   logic               busy0, busy1, done0, done1;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   iter_shifter #(.WIDTH(W), .SHAMT_W(SW), .STEP(1)) u_dut_s1 (
      .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode_v[0]),
      .shamt(shamt_v[0]), .din(din_v[0]), .dout(dout0), .busy(busy0), .done(done0)
   );

   iter_shifter #(.WIDTH(W), .SHAMT_W(SW), .STEP(4)) u_dut_s4 (
      .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode_v[1]),
      .shamt(shamt_v[1]), .din(din_v[1]), .dout(dout1), .busy(busy1), .done(done1)
   );

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: apply the shift one bit at a time, independent of STEP
   function automatic logic [W-1:0] ref_shift(input logic [1:0] m, input int n, input logic [W-1:0] x0);
      logic [W-1:0] x;
      x = x0;
      for (int i = 0; i < n; i++) begin
         case (m)
            2'b01: x = {1'b0, x[W-1:1]};
            2'b10: x = {x[W-1], x[W-1:1]};
`ifdef ITER_SHIFTER_ROTATE_EN
            2'b11: x = {x[W-2:0], x[W-1]};
`else
            2'b11: x = {x[W-2:0], 1'b0};
`endif
            default: x = {x[W-2:0], 1'b0};
         endcase
      end
      return x;
   endfunction

   function automatic int ref_lat(input int n, input int step);
      return (n == 0) ? 0 : (n + step - 1) / step;
   endfunction

   function automatic logic done_of(input int i);
      return (i == 0) ? done0 : done1;
   endfunction

   function automatic logic busy_of(input int i);
      return (i == 0) ? busy0 : busy1;
   endfunction

   // Called at a negedge: drive one start pulse and record the expected result and done cycle
   task automatic start_op(input int i, input logic [1:0] m, input int n, input logic [W-1:0] x);
      exp_t e;
      e.val = ref_shift(m, n, x);
      e.cyc = cyc + 1 + ref_lat(n, (i == 0) ? 1 : 4);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
      start_v[i] = 1'b1;
      mode_v[i]  = m;
      shamt_v[i] = n[SW-1:0];
      din_v[i]   = x;
      @(negedge clk);
      start_v[i] = 1'b0;
      mode_v[i]  = 2'($urandom);
      shamt_v[i] = SW'($urandom);
      din_v[i]   = $urandom;
   endtask

   task automatic wait_done(input int i);
      for (int t = 0; t < 200; t++) begin
         if (done_of(i)) return;
         @(negedge clk);
      end
      check_eq("done_timeout", {31'b0, done_of(i)}, 1);
   endtask

   // Scoreboard: every done pulse pops one expectation and checks value and latency
   always @(negedge clk) begin
      if (!reset) begin
         if (done0) begin
            if (q0.size() == 0) check_eq("spurious_done_s1", {31'b0, done0}, 0);
            else begin
               exp_t e;
               e = q0.pop_front();
               check_eq("dout_s1", dout0, e.val);
               check_eq("lat_s1", cyc, e.cyc);
            end
         end
         if (done1) begin
            if (q1.size() == 0) check_eq("spurious_done_s4", {31'b0, done1}, 0);
            else begin
               exp_t e;
               e = q1.pop_front();
               check_eq("dout_s4", dout1, e.val);
               check_eq("lat_s4", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      start_v = '0;
      mode_v  = '0;
      shamt_v = '0;
      din_v   = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_dout", dout0, 0);
      check_eq("rst_busy", {31'b0, busy0}, 0);
      check_eq("rst_done", {31'b0, done0}, 0);
      reset = 1'b0;
      @(negedge clk);

      // SLL by 2 reproduces the legacy shift-left-2
      start_op(0, 2'b00, 2, 32'h0000_0001);
      check_eq("busy_in_shift", {31'b0, busy0}, 1);
      wait_done(0);
      @(negedge clk);

      // Full-width SRA then SRL back-to-back in the DONE cycle
      start_op(0, 2'b10, 31, 32'h8000_0000);
      wait_done(0);
      start_op(0, 2'b01, 31, 32'h8000_0000);
      wait_done(0);
      @(negedge clk);

      // shamt=0 goes straight to DONE, busy never rises, dout then holds
      start_op(0, 2'b01, 0, 32'h1234_5678);
      check_eq("busy_shamt0", {31'b0, busy0}, 0);
      wait_done(0);
      @(negedge clk);
      check_eq("done_one_cycle", {31'b0, done0}, 0);
      check_eq("dout_hold", dout0, 32'h1234_5678);

      // start while busy is ignored
      start_op(0, 2'b00, 8, 32'h0000_000F);
      @(negedge clk);
      start_v[0] = 1'b1;
      shamt_v[0] = 5'd1;
      din_v[0]   = 32'h0000_0001;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_done(0);
      @(negedge clk);

      // Reset mid-operation clears outputs without a clock edge
      start_op(0, 2'b00, 8, 32'h0000_000F);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_eq("abort_busy", {31'b0, busy0}, 0);
      check_eq("abort_done", {31'b0, done0}, 0);
      check_eq("abort_dout", dout0, 0);
      q0.delete();
      q1.delete();
      @(negedge clk);
      reset = 1'b0;
      start_op(0, 2'b00, 5, 32'h0000_0003);
      wait_done(0);
      @(negedge clk);

      // mode 11: rotate-left when enabled, SLL otherwise
      start_op(0, 2'b11, 4, 32'h8000_0001);
      wait_done(0);
      @(negedge clk);

      // STEP=4 instance: partial final step and sub-STEP single step
      start_op(1, 2'b00, 10, 32'h0000_0001);
      wait_done(1);
      @(negedge clk);
      start_op(1, 2'b10, 3, 32'hF000_0000);
      check_eq("busy_s4", {31'b0, busy_of(1)}, 1);
      wait_done(1);
      start_op(1, 2'b00, 31, 32'hFFFF_FFFF);
      wait_done(1);
      @(negedge clk);

      // Random operations on both instances, some back-to-back
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 24; k++) begin
            start_op(i, 2'($urandom), int'($urandom_range(0, W - 1)), $urandom);
            wait_done(i);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
         end
      end

      repeat (3) @(negedge clk);
      check_eq("q_s1_drained", q0.size(), 0);
      check_eq("q_s4_drained", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
